// File: rtl/core_pkg.sv
// Shared opcode constants and enums for the instruction loader and its encoder.
package core_pkg;

  localparam logic [6:0] OPC_R      = 7'b1100110;
  localparam logic [6:0] OPC_LOAD   = 7'b1100000;
  localparam logic [6:0] OPC_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_STORE  = 7'b1100010;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef enum logic [2:0] {
    CLASS_R      = 3'd0,
    CLASS_LOAD   = 3'd1,
    CLASS_IMM    = 3'd2,
    CLASS_STORE  = 3'd3,
    CLASS_BRANCH = 3'd4
  } op_class_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } ldr_state_e;

endpackage

// File: rtl/instr_mem_loader_if.sv
// Descriptor input handshake plus instruction-memory write port of the loader.
interface instr_mem_loader_if #(
  parameter int ADDR_WIDTH = 10
);
  logic                  i_valid;
  logic                  o_ready;
  logic [2:0]            i_op_class;
  logic [4:0]            i_rd;
  logic [4:0]            i_rs1;
  logic [4:0]            i_rs2;
  logic [2:0]            i_funct3;
  logic [6:0]            i_funct7;
  logic [12:0]           i_imm;
  logic                  i_last;
  logic                  o_imem_we;
  logic                  i_imem_ready;
  logic [ADDR_WIDTH-1:0] o_imem_addr;
  logic [31:0]           o_imem_wdata;

  modport slave (
    input  i_valid, i_op_class, i_rd, i_rs1, i_rs2, i_funct3, i_funct7, i_imm, i_last,
    input  i_imem_ready,
    output o_ready, o_imem_we, o_imem_addr, o_imem_wdata
  );

  modport master (
    output i_valid, i_op_class, i_rd, i_rs1, i_rs2, i_funct3, i_funct7, i_imm, i_last,
    output i_imem_ready,
    input  o_ready, o_imem_we, o_imem_addr, o_imem_wdata
  );
endinterface

// File: rtl/instr_field_encoder.sv
// Combinational descriptor-to-instruction-word encoder; flags descriptors it cannot encode.
module instr_field_encoder
  import core_pkg::*;
(
  input  logic [2:0]  op_class,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [12:0] imm,
  output logic [31:0] word,
  output logic        illegal
);

  always_comb begin
    word    = '0;
    illegal = 1'b0;
    case (op_class)
      CLASS_R:     word = {funct7, rs2, rs1, funct3, rd, OPC_R};
      CLASS_LOAD:  word = {imm[11:0], rs1, funct3, rd, OPC_LOAD};
      CLASS_IMM:   word = {imm[11:0], rs1, funct3, rd, OPC_IMM};
      CLASS_STORE: word = {imm[11:5], rs2, rs1, funct3, imm[4:0], OPC_STORE};
      CLASS_BRANCH: begin
        // Branch offsets are halfword aligned, so an odd immediate cannot be encoded.
        word    = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OPC_BRANCH};
        illegal = imm[0];
      end
      default:     illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_mem_loader.sv
// Session-based instruction writer: encodes descriptors, queues them in a small FIFO
// and writes them to consecutive instruction-memory addresses.
module instr_mem_loader
  import core_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH-1:0] i_base_addr,
  instr_mem_loader_if.slave     bus,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_err,
  output logic [ADDR_WIDTH:0]   o_count
);

  localparam int                    PTR_W    = $clog2(DEPTH);
  localparam logic [PTR_W:0]        OCC_FULL = (PTR_W + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = '1;

  ldr_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  err_q, err_d;
  logic                  ovf_q, ovf_d;
  logic [PTR_W:0]        occ_q, occ_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [31:0]           fifo_q [DEPTH];

  logic [31:0] enc_word;
  logic        enc_illegal;
  logic        ready, accept, push, pop, imem_we, writer_on;

  instr_field_encoder u_enc (
    .op_class (bus.i_op_class),
    .rd       (bus.i_rd),
    .rs1      (bus.i_rs1),
    .rs2      (bus.i_rs2),
    .funct3   (bus.i_funct3),
    .funct7   (bus.i_funct7),
    .imm      (bus.i_imm),
    .word     (enc_word),
    .illegal  (enc_illegal)
  );

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    count_d   = count_q;
    err_d     = err_q;
    ovf_d     = ovf_q;
    occ_d     = occ_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    push      = 1'b0;
    pop       = 1'b0;
    imem_we   = 1'b0;
    writer_on = (state_q == ST_LOAD) || (state_q == ST_DRAIN);
    // Ready looks only at registered occupancy, so a same-cycle pop never frees a slot.
    ready     = (state_q == ST_LOAD) && (occ_q != OCC_FULL);
    accept    = bus.i_valid && ready;

    if (accept) begin
      if (enc_illegal) err_d = 1'b1;
      else             push  = 1'b1;
    end

    if (writer_on && (occ_q != '0)) begin
      if (ovf_q) begin
        // Past the top of memory: discard queued words instead of wrapping.
        pop   = 1'b1;
        err_d = 1'b1;
      end else begin
        imem_we = 1'b1;
        if (bus.i_imem_ready) begin
          pop     = 1'b1;
          count_d = count_q + 1'b1;
          if (addr_q == ADDR_MAX) ovf_d  = 1'b1;
          else                    addr_d = addr_q + 1'b1;
        end
      end
    end

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase

    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          state_d = ST_LOAD;
          addr_d  = i_base_addr;
          count_d = '0;
          err_d   = 1'b0;
          ovf_d   = 1'b0;
        end
      end
      ST_LOAD:  if (accept && bus.i_last) state_d = ST_DRAIN;
      ST_DRAIN: if (occ_d == '0) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
      ovf_q    <= 1'b0;
      occ_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      count_q  <= count_d;
      err_q    <= err_d;
      ovf_q    <= ovf_d;
      occ_q    <= occ_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push && !i_rst) fifo_q[wr_ptr_q] <= enc_word;
  end

  assign bus.o_ready      = ready;
  assign bus.o_imem_we    = imem_we;
  assign bus.o_imem_addr  = addr_q;
  assign bus.o_imem_wdata = imem_we ? fifo_q[rd_ptr_q] : '0;
  assign o_busy           = (state_q != ST_IDLE);
  assign o_done           = (state_q == ST_DONE);
  assign o_err            = err_q;
  assign o_count          = count_q;

endmodule

// File: doc/instr_mem_loader.md
# instr_mem_loader

Sequential instruction writer for the single-cycle core. It accepts decoded-field descriptors (operation class plus register, funct and immediate fields) through a valid/ready port and encodes each one into a 32-bit instruction word. The words pass through a small FIFO and are written to consecutive instruction-memory word addresses through a write handshake. It sits beside the instruction memory and produces exactly the opcode set that the main control decoder consumes; testbenches and boot logic use it to load programs.

## Interface
- DEPTH, 4: FIFO entries (power of two, ≥2)
- ADDR_WIDTH, 10: instruction-memory word-address width
- i_clk  in  1  clock; the block has one clock
- i_rst  in  1  reset; synchronous, active-high
- i_start  in  1  begins a load session; ignored unless the block is idle
- i_base_addr  in  ADDR_WIDTH  first word address, sampled on i_start
- i_valid / o_ready  in/out  1  descriptor handshake
- i_op_class  in  3  0=R, 1=LOAD, 2=IMM, 3=STORE, 4=BRANCH; 5–7 invalid
- i_rd, i_rs1, i_rs2  in  5 each  register fields
- i_funct3  in  3; i_funct7  in  7 (used by R only)
- i_imm  in  13  signed immediate; bits [11:0] for I/S, [12:1] for B
- i_last  in  1  marks the final descriptor of the session
- o_imem_we  out  1  write request; held until acknowledged
- i_imem_ready  in  1  write acknowledge
- o_imem_addr  out  ADDR_WIDTH; o_imem_wdata  out  32
- o_busy  out  1; o_done  out  1 (one-cycle pulse); o_err  out  1 (sticky)
- o_count  out  ADDR_WIDTH+1  words written in this session

## Operation
- **Opcodes** (from core_pkg): R=1100110, LOAD=1100000, IMM=0010011, STORE=1100010, BRANCH=1100011.
- **Encodings**:
  - R: {f7,rs2,rs1,f3,rd,op}
  - LOAD/IMM: {imm[11:0],rs1,f3,rd,op}
  - STORE: {imm[11:5],rs2,rs1,f3,imm[4:0],op}
  - BRANCH: {imm[12],imm[10:5],rs2,rs1,f3,imm[4:1],imm[11],op}
- **FSM IDLE**: o_ready=0. On i_start: go to LOAD, set addr←i_base_addr, count←0, err←0.
- **FSM LOAD**: o_ready = !fifo_full && !last_accepted. An accept (i_valid&&o_ready) pushes the encoded word. Accepting i_last moves the FSM to DRAIN.
- **FSM DRAIN**: once the FIFO is empty and o_imem_we=0, go to DONE.
- **FSM DONE**: o_done=1 for one cycle, then IDLE.
- **Writer** (runs in LOAD and DRAIN): o_imem_we=1 whenever the FIFO is non-empty, with wdata=head and addr=current address. On i_imem_ready: pop, addr+1, count+1.
- **Error: invalid op_class, or BRANCH with i_imm[0]=1**: the descriptor is still accepted (a handshake occurs) but is not pushed. o_err←1.
- **Error: overflow**: after the write at address 2^ADDR_WIDTH−1, later FIFO entries are popped without a write (o_imem_we stays 0). o_err←1. The address does not wrap.
- o_err stays set until the next i_start.
- o_ready depends only on the registered FIFO occupancy. It is 0 when the FIFO is full, even if a pop happens in the same cycle.
- A simultaneous push and pop leaves the occupancy unchanged.

## Timing
- A descriptor accepted in cycle N can drive o_imem_we in cycle N+1 at the earliest.
- Sustained throughput: 1 word/cycle while i_imem_ready=1.
- o_imem_addr and o_imem_wdata are stable while o_imem_we=1 and i_imem_ready=0.
- o_done rises the cycle after the last acknowledge, in the DONE state.
- **Reset values**: state IDLE, FIFO empty, o_ready=0, o_imem_we=0, o_imem_addr=0, o_imem_wdata=0, o_busy=0, o_done=0, o_err=0, o_count=0.
- **Reset mid-session**: i_rst takes priority over every other input. Queued entries are discarded and no write is issued in the cycle after reset.
- o_busy=1 in the LOAD, DRAIN and DONE states.

## Structure
- **core_pkg**: opcode localparams, op_class enum, FSM state enum.
- **instr_field_encoder**: purely combinational sub-module that maps a descriptor to {word, illegal}.
- **instr_mem_loader**: contains the FIFO (register array with wrapping pointers), the FSM, and the address/count logic.

## Test plan
- **R-format**: base=0x010, R rd=3 rs1=1 rs2=2 f3=0 f7=0 with i_last, i_imem_ready=1 → one write of 0x002081E6 at 0x010; o_done pulse; o_count=1.
- **STORE and BRANCH**:
  - STORE imm=−4 rs1=2 rs2=5 f3=3 → 0xFE513E62.
  - BRANCH imm=8 rs1=1 rs2=2 f3=0 → 0x00208463, at consecutive addresses.
- **Errors**: BRANCH imm=9, and op_class=6 → both accepted, nothing written, o_err=1 until the next i_start.
- **Backpressure**: DEPTH=4, 6 descriptors with i_imem_ready=0 for 10 cycles → o_ready drops after 4 accepts; all 6 words are written in order to base..base+5.
- **Overflow**: ADDR_WIDTH=2, base=3, two descriptors → a single write at address 3; o_err=1; o_count=1; o_done still pulses.
- **Reset mid-drain**: 2 entries queued, assert i_rst → the next cycle shows o_imem_we=0, o_busy=0, o_count=0. A new session then writes from its own base.
